// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with bounded grant hold.
// Registers a one-hot grant plus its binary index and a valid flag.
module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [3:0] req_i,
  output logic [3:0] gnt_o,
  output logic [1:0] gnt_idx_o,
  output logic       gnt_valid_o
);

  localparam int unsigned CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      owner_q, owner_d;
  logic [CW-1:0]   hold_q, hold_d;
  logic [3:0]      gnt_q, gnt_d;
  logic [1:0]      idx_q, idx_d;
  logic            vld_q, vld_d;

  logic [3:0]      others;
  logic [2:0]      win_all, win_oth;
  logic            take;
  logic [1:0]      take_idx;

  // Returns {found, index}: first set bit scanning p, p+1, p+2, p+3 mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] j;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      j = p + 2'(k);
      if (r[j]) res = {1'b1, j};
    end
    return res;
  endfunction

  always_comb begin
    others  = req_i & ~(4'b0001 << owner_q);
    win_all = rr_pick(req_i, ptr_q);
    win_oth = rr_pick(others, ptr_q);

    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    hold_d   = hold_q;
    take     = 1'b0;
    take_idx = 2'd0;

    case (state_q)
      IDLE: begin
        if (en_i && win_all[2]) begin
          take     = 1'b1;
          take_idx = win_all[1:0];
        end
      end
      GRANT: begin
        if (!en_i) begin
          state_d = IDLE;
        end else if (!req_i[owner_q]) begin
          if (win_all[2]) begin
            take     = 1'b1;
            take_idx = win_all[1:0];
          end else begin
            state_d = IDLE;
          end
        end else if (hold_q == HOLD_LAST && win_oth[2]) begin
          // ptr already points past the owner, so it is scanned last
          take     = 1'b1;
          take_idx = win_oth[1:0];
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (take) begin
      state_d = GRANT;
      owner_d = take_idx;
      ptr_d   = take_idx + 2'd1;
      hold_d  = '0;
    end

    vld_d = (state_d == GRANT);
    gnt_d = vld_d ? (4'b0001 << owner_d) : 4'b0000;
    idx_d = vld_d ? owner_d : 2'd0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      owner_q <= 2'd0;
      hold_q  <= '0;
      gnt_q   <= 4'b0000;
      idx_q   <= 2'd0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_idx_o   = idx_q;
  assign gnt_valid_o = vld_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: two instances (MAX_HOLD=8 and 1) on shared stimulus,
// each checked against an integer ownership model every cycle.
module tb_rr_arbiter4;
  logic       clk = 1'b0;
  logic       rst, en;
  logic [3:0] req;
  logic [3:0] g0, g1;
  logic [1:0] i0, i1;
  logic       v0, v1;

  int total = 0;
  int bad   = 0;

  int m_own  [2];
  int m_ptr  [2];
  int m_held [2];
  int mh     [2] = '{8, 1};

  always #5 clk = ~clk;

  rr_arbiter4 #(.MAX_HOLD(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .req_i(req),
    .gnt_o(g0), .gnt_idx_o(i0), .gnt_valid_o(v0));

  rr_arbiter4 #(.MAX_HOLD(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .req_i(req),
    .gnt_o(g1), .gnt_idx_o(i1), .gnt_valid_o(v1));

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic give(input int d, input int i);
    m_own[d]  = i;
    m_ptr[d]  = (i + 1) % 4;
    m_held[d] = 1;
  endtask

  // Ownership model: m_held counts cycles the current owner has had the grant.
  task automatic model_step(input int d);
    logic [3:0] oth;
    if (rst) begin
      m_own[d] = -1; m_ptr[d] = 0; m_held[d] = 0;
    end else if (m_own[d] < 0) begin
      if (en && req != 4'b0) give(d, pick(req, m_ptr[d]));
    end else if (!en) begin
      m_own[d] = -1;
    end else if (!req[m_own[d]]) begin
      if (req != 4'b0) give(d, pick(req, m_ptr[d]));
      else m_own[d] = -1;
    end else begin
      oth = req;
      oth[m_own[d]] = 1'b0;
      if (m_held[d] >= mh[d] && oth != 4'b0) give(d, pick(oth, m_ptr[d]));
      else m_held[d]++;
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] act, input logic [3:0] exp);
    total++;
    assert (act === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic check_model();
    logic [3:0] eg;
    logic [1:0] ei;
    for (int d = 0; d < 2; d++) begin
      eg = (m_own[d] < 0) ? 4'b0000 : 4'(1 << m_own[d]);
      ei = (m_own[d] < 0) ? 2'd0 : 2'(m_own[d]);
      chk(d == 0 ? "gnt8" : "gnt1", d == 0 ? g0 : g1, eg);
      chk(d == 0 ? "idx8" : "idx1", d == 0 ? {2'b0, i0} : {2'b0, i1}, {2'b0, ei});
      chk(d == 0 ? "vld8" : "vld1", d == 0 ? {3'b0, v0} : {3'b0, v1},
          {3'b0, (m_own[d] >= 0)});
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [3:0] q, input int n);
    rst = r; en = e; req = q;
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      check_model();
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_own[d] = -1; m_ptr[d] = 0; m_held[d] = 0;
    end
    rst = 1'b1; en = 1'b1; req = 4'b1111;
    @(negedge clk);

    // reset dominates en/req
    step(1'b1, 1'b1, 4'b1111, 2);
    chk("rst_gnt", g0, 4'b0000);
    chk("rst_vld", {3'b0, v0}, 4'b0000);
    step(1'b0, 1'b1, 4'b1111, 1);
    chk("first_gnt", g0, 4'b0001);

    // single requester, then release to idle
    step(1'b1, 1'b1, 4'b0000, 1);
    step(1'b0, 1'b1, 4'b0100, 20);
    chk("single_gnt", g0, 4'b0100);
    step(1'b0, 1'b1, 4'b0000, 1);
    chk("single_rel", g0, 4'b0000);

    // full contention: 8-cycle slots vs one-cycle rotation
    step(1'b1, 1'b1, 4'b0000, 1);
    step(1'b0, 1'b1, 4'b1111, 40);

    // release handoff without a bubble
    step(1'b1, 1'b1, 4'b0000, 1);
    step(1'b0, 1'b1, 4'b1011, 1);
    chk("hand_own0", g0, 4'b0001);
    step(1'b0, 1'b1, 4'b1010, 1);
    chk("hand_gnt", g0, 4'b0010);
    chk("hand_vld", {3'b0, v0}, 4'b0001);

    // enable drop keeps the pointer
    step(1'b1, 1'b1, 4'b0000, 1);
    step(1'b0, 1'b1, 4'b0010, 1);
    step(1'b0, 1'b0, 4'b1111, 1);
    chk("endrop_gnt", g0, 4'b0000);
    step(1'b0, 1'b1, 4'b1111, 1);
    chk("enback_gnt", g0, 4'b0100);

    // reset mid-grant returns pointer to 0
    step(1'b0, 1'b1, 4'b1111, 3);
    step(1'b1, 1'b1, 4'b1111, 1);
    chk("midrst_gnt", g0, 4'b0000);
    step(1'b0, 1'b1, 4'b1111, 1);
    chk("midrst_ptr", g0, 4'b0001);

    // randomized traffic with sticky request patterns so timeouts occur
    for (int n = 0; n < 3000; n++) begin
      logic       r, e;
      logic [3:0] q;
      r = ($urandom_range(0, 199) == 0);
      e = ($urandom_range(0, 19) != 0);
      q = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : req;
      step(r, e, q, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "bench time limit reached");
  end
endmodule
